// File: rtl/hazard_scoreboard.sv
// Producer-side hazard scoreboard sitting at ID/EX.
// Each architectural register (x1..x31) has a down-counter holding the number
// of cycles until its pending result becomes forwardable. The instruction in
// ID is held back while any source it reads is still pending, while its
// destination would be overwritten out of order by an older slow producer, or
// while the single MUL/DIV unit is occupied.
module hazard_scoreboard #(
  parameter int LOAD_LAT = 1,
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] ID_RS1addr_i,
  input  logic [4:0] ID_RS2addr_i,
  input  logic       ID_RS1use_i,
  input  logic       ID_RS2use_i,
  input  logic [4:0] ID_RDaddr_i,
  input  logic       ID_RegWrite_i,
  input  logic       ID_MemRead_i,
  input  logic       ID_Long_i,
  input  logic       ID_valid_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic       bubble_o,
  output logic       issue_o,
  output logic       long_busy_o
);

  localparam logic [CNT_W-1:0] LOAD_LAT_C = CNT_W'(LOAD_LAT);
  localparam logic [CNT_W-1:0] LONG_LAT_C = CNT_W'(LONG_LAT);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  // x0 is hard-wired zero, so it never gets a counter.
  logic [CNT_W-1:0] cnt [1:31];
  logic [CNT_W-1:0] long_cnt;

  logic [CNT_W-1:0] rs1_cnt;
  logic [CNT_W-1:0] rs2_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] lat_new;
  logic             raw_hz;
  logic             waw_hz;
  logic             struct_hz;
  logic             hz;

  // Counter step that stops at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    return (v == CNT_ZERO) ? CNT_ZERO : v - CNT_W'(1);
  endfunction

  // Read a register's pending count; x0 always reads as not pending.
  function automatic logic [CNT_W-1:0] pending(input logic [4:0] addr,
                                               input logic [CNT_W-1:0] tbl [1:31]);
    logic [CNT_W-1:0] v;
    v = CNT_ZERO;
    for (int i = 1; i < 32; i++) begin
      if (addr == 5'(i)) v = tbl[i];
    end
    return v;
  endfunction

  // Hazard detection and pipeline control, purely combinational from state.
  always_comb begin
    rs1_cnt = pending(ID_RS1addr_i, cnt);
    rs2_cnt = pending(ID_RS2addr_i, cnt);
    rd_cnt  = pending(ID_RDaddr_i, cnt);

    if (ID_Long_i)         lat_new = LONG_LAT_C;
    else if (ID_MemRead_i) lat_new = LOAD_LAT_C;
    else                   lat_new = CNT_ZERO;

    raw_hz = (ID_RS1use_i && (ID_RS1addr_i != 5'd0) && (rs1_cnt != CNT_ZERO)) ||
             (ID_RS2use_i && (ID_RS2addr_i != 5'd0) && (rs2_cnt != CNT_ZERO));
    // A newer, faster producer must not land before an older, slower one.
    waw_hz    = ID_RegWrite_i && (ID_RDaddr_i != 5'd0) && (rd_cnt > lat_new);
    struct_hz = ID_Long_i && (long_cnt != CNT_ZERO);

    hz          = ID_valid_i && !flush_i && (raw_hz || waw_hz || struct_hz);
    stall_o     = hz;
    bubble_o    = hz || flush_i;
    issue_o     = ID_valid_i && !flush_i && !hz;
    long_busy_o = (long_cnt != CNT_ZERO);
  end

  // Age all pending entries each cycle; an issuing writer reloads its entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < 32; i++) cnt[i] <= CNT_ZERO;
      long_cnt <= CNT_ZERO;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (issue_o && ID_RegWrite_i && (ID_RDaddr_i == 5'(i)))
          cnt[i] <= lat_new;
        else
          cnt[i] <= dec_sat(cnt[i]);
      end
      if (issue_o && ID_Long_i) long_cnt <= LONG_LAT_C;
      else                      long_cnt <= dec_sat(long_cnt);
    end
  end

endmodule
